mem_access_unit: RTL and testbench

//  Parametrised load/store engine for the MEM stage. Splits one LB/LBU/LH/LHU/LW/SB/SH/SW

---
 rtl/mem_access_if.sv | 38 +++
 rtl/mem_access_unit.sv | 204 ++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_if.sv
// Handshake and RAM-port bundle for mem_access_unit.
// The master modport is the access unit's own view: it takes the pipeline
// request and drives the arbitrated RAM port. The slave modport is the view of
// everything around the unit (MEM stage, arbiter, RAM).
interface mem_access_if #(
    parameter int BUS_BYTES = 1
);
    logic                     req_i;
    logic                     store_i;
    logic [1:0]               size_i;
    logic                     unsigned_i;
    logic [31:0]              addr_i;
    logic [31:0]              wdata_i;
    logic                     busy_o;
    logic                     done_o;
    logic [31:0]              rdata_o;
    logic                     mem_req_o;
    logic                     mem_gnt_i;
    logic                     mem_we_o;
    logic [31:0]              mem_addr_o;
    logic [BUS_BYTES-1:0]     mem_be_o;
    logic [8*BUS_BYTES-1:0]   mem_wdata_o;
    logic [8*BUS_BYTES-1:0]   mem_rdata_i;

    modport master (
        input  req_i, store_i, size_i, unsigned_i, addr_i, wdata_i,
        input  mem_gnt_i, mem_rdata_i,
        output busy_o, done_o, rdata_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o
    );

    modport slave (
        output req_i, store_i, size_i, unsigned_i, addr_i, wdata_i,
        output mem_gnt_i, mem_rdata_i,
        input  busy_o, done_o, rdata_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: splits one byte/half/word access into
// BUS_BYTES-wide beats on a shared RAM port, reassembles and extends loads.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for req_i; operands latched on accept
// ISSUE | requesting beats; a beat advances only when granted
// DRAIN | all read beats issued, waiting for the last one to return
// DONE  | one-cycle done_o pulse, rdata_o already updated for loads
module mem_access_unit #(
    parameter int BUS_BYTES = 1,
    parameter int RD_LAT    = 1
) (
    input  logic          clk,
    input  logic          rst,
    mem_access_if.master  mif
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t         state_q, state_d;

    logic           store_q;
    logic           unsigned_q;
    logic [1:0]     size_q;
    logic [31:0]    addr_q;
    logic [31:0]    wdata_q;
    logic [2:0]     nbytes_q;
    logic [1:0]     last_beat_q;
    logic [1:0]     beat_q;
    logic [31:0]    buf_q;
    logic [31:0]    rdata_q;

    // Return tags: stage RD_LAT-1 holds the beat whose data is on mem_rdata_i now.
    logic           pipe_vld_q [RD_LAT];
    logic [1:0]     pipe_idx_q [RD_LAT];

    logic [2:0]     nbytes_d;
    logic [1:0]     last_beat_d;
    logic           accept;
    logic           fire;
    logic           ret_vld;
    logic [1:0]     ret_idx;
    logic           ret_last;
    logic [31:0]    buf_d;

    logic                   busy_c;
    logic                   done_c;
    logic                   mem_req_c;
    logic                   mem_we_c;
    logic [31:0]            mem_addr_c;
    logic [BUS_BYTES-1:0]   mem_be_c;
    logic [8*BUS_BYTES-1:0] mem_wdata_c;

    assign accept   = (state_q == IDLE) && mif.req_i;
    assign fire     = (state_q == ISSUE) && mif.mem_gnt_i;
    assign ret_vld  = pipe_vld_q[RD_LAT-1];
    assign ret_idx  = pipe_idx_q[RD_LAT-1];
    // Beats return in order, so the last index seen ends the load.
    assign ret_last = ret_vld && (ret_idx == last_beat_q);

    // Access size in bytes and index of the final beat for the incoming request.
    always_comb begin
        nbytes_d = 3'd4;
        case (mif.size_i)
            2'd0:    nbytes_d = 3'd1;
            2'd1:    nbytes_d = 3'd2;
            default: nbytes_d = 3'd4;
        endcase
        last_beat_d = 2'((int'(nbytes_d) + BUS_BYTES - 1) / BUS_BYTES - 1);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; DRAIN exit is driven by the return tags, not by ISSUE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (mif.req_i) state_d = ISSUE;
            ISSUE:   if (fire && (beat_q == last_beat_q))
                         state_d = store_q ? DONE : DRAIN;
            DRAIN:   if (ret_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand capture on accept; held stable for the whole access.
    always_ff @(posedge clk) begin
        if (rst) begin
            store_q     <= 1'b0;
            unsigned_q  <= 1'b0;
            size_q      <= 2'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            nbytes_q    <= 3'd0;
            last_beat_q <= 2'd0;
        end else if (accept) begin
            store_q     <= mif.store_i;
            unsigned_q  <= mif.unsigned_i;
            size_q      <= mif.size_i;
            addr_q      <= mif.addr_i;
            wdata_q     <= mif.wdata_i;
            nbytes_q    <= nbytes_d;
            last_beat_q <= last_beat_d;
        end
    end

    // Beat counter advances only on a granted beat.
    always_ff @(posedge clk) begin
        if (rst)                  beat_q <= 2'd0;
        else if (state_q == IDLE) beat_q <= 2'd0;
        else if (fire)            beat_q <= beat_q + 2'd1;
    end

    // Read-latency tag pipe for granted load beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_vld_q[i] <= 1'b0;
                pipe_idx_q[i] <= 2'd0;
            end
        end else begin
            pipe_vld_q[0] <= fire && !store_q;
            pipe_idx_q[0] <= beat_q;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_idx_q[i] <= pipe_idx_q[i-1];
            end
        end
    end

    // Merge the returning lanes into the assembly buffer at their byte offsets.
    always_comb begin
        buf_d = buf_q;
        for (int j = 0; j < BUS_BYTES; j++) begin
            if ((int'(ret_idx) * BUS_BYTES + j) < 4)
                buf_d[8*(int'(ret_idx)*BUS_BYTES + j) +: 8] = mif.mem_rdata_i[8*j +: 8];
        end
    end

    function automatic logic [31:0] extend(input logic [31:0] v, input logic [1:0] sz,
                                           input logic uns);
        logic [31:0] r;
        case (sz)
            2'd0:    r = uns ? {24'd0, v[7:0]}  : {{24{v[7]}},  v[7:0]};
            2'd1:    r = uns ? {16'd0, v[15:0]} : {{16{v[15]}}, v[15:0]};
            default: r = v;
        endcase
        return r;
    endfunction

    // Assembly buffer and load result; rdata is written as the last beat lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q   <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            if (accept)
                buf_q <= 32'd0;
            else if (ret_vld)
                buf_q <= buf_d;
            if (ret_last && !store_q)
                rdata_q <= extend(buf_d, size_q, unsigned_q);
        end
    end

    // Bus and status outputs; everything outside ISSUE is driven to zero.
    always_comb begin
        busy_c      = (state_q == ISSUE) || (state_q == DRAIN);
        done_c      = (state_q == DONE);
        mem_req_c   = 1'b0;
        mem_we_c    = 1'b0;
        mem_addr_c  = 32'd0;
        mem_be_c    = '0;
        mem_wdata_c = '0;
        if (state_q == ISSUE) begin
            mem_req_c  = 1'b1;
            mem_we_c   = store_q;
            mem_addr_c = addr_q + (32'(beat_q) * 32'(BUS_BYTES));
            for (int j = 0; j < BUS_BYTES; j++) begin
                if ((int'(beat_q) * BUS_BYTES + j) < int'(nbytes_q)) begin
                    mem_be_c[j] = 1'b1;
                    if (store_q)
                        mem_wdata_c[8*j +: 8] = wdata_q[8*(int'(beat_q)*BUS_BYTES + j) +: 8];
                end
            end
        end
    end

    assign mif.busy_o      = busy_c;
    assign mif.done_o      = done_c;
    assign mif.rdata_o     = rdata_q;
    assign mif.mem_req_o   = mem_req_c;
    assign mif.mem_we_o    = mem_we_c;
    assign mif.mem_addr_o  = mem_addr_c;
    assign mif.mem_be_o    = mem_be_c;
    assign mif.mem_wdata_o = mem_wdata_c;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit in three bus/latency configurations:
// u1 (1 byte, latency 1), u2 (2 bytes, latency 3), u4 (4 bytes, latency 2).
module tb_mem_access_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_access_if #(.BUS_BYTES(1)) m1 ();
    mem_access_if #(.BUS_BYTES(2)) m2 ();
    mem_access_if #(.BUS_BYTES(4)) m4 ();

    mem_access_unit #(.BUS_BYTES(1), .RD_LAT(1)) u1 (.clk(clk), .rst(rst), .mif(m1));
    mem_access_unit #(.BUS_BYTES(2), .RD_LAT(3)) u2 (.clk(clk), .rst(rst), .mif(m2));
    mem_access_unit #(.BUS_BYTES(4), .RD_LAT(2)) u4 (.clk(clk), .rst(rst), .mif(m4));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ram_b(input logic [31:0] a);
        case (a)
            32'h100: return 8'h11;
            32'h101: return 8'h22;
            32'h102: return 8'h33;
            32'h103: return 8'h44;
            32'h200: return 8'h80;
            32'h201: return 8'h7F;
            32'h401: return 8'h01;
            32'h402: return 8'h02;
            32'h403: return 8'h03;
            32'h404: return 8'h04;
            default: return 8'h00;
        endcase
    endfunction

    // ---------------- bus monitors and RAM read models ----------------
    logic [31:0] q1_addr [$];
    logic [7:0]  q1_wd   [$];
    logic        q1_be   [$];
    logic        q1_we   [$];
    int          done1_cnt = 0, done1_cyc = 0;
    logic [31:0] done1_rd;
    logic        g1 = 1'b0;
    logic [31:0] ga1 = 32'd0;
    logic        rp1_v = 1'b0;
    logic [7:0]  rp1_d = 8'd0;

    always @(negedge clk) begin
        g1  = m1.mem_req_o && m1.mem_gnt_i && !m1.mem_we_o;
        ga1 = m1.mem_addr_o;
        if (m1.mem_req_o && m1.mem_gnt_i) begin
            q1_addr.push_back(m1.mem_addr_o);
            q1_wd.push_back(m1.mem_wdata_o);
            q1_be.push_back(m1.mem_be_o[0]);
            q1_we.push_back(m1.mem_we_o);
        end
        if (m1.done_o) begin
            done1_cnt++;
            done1_cyc = cyc;
            done1_rd  = m1.rdata_o;
        end
    end

    always @(posedge clk) begin
        rp1_v <= rst ? 1'b0 : g1;
        rp1_d <= ram_b(ga1);
    end
    assign m1.mem_rdata_i = rp1_v ? rp1_d : 8'hEE;

    logic [31:0] q2_addr [$];
    int          done2_cnt = 0, done2_cyc = 0;
    logic [31:0] done2_rd;
    logic        g2 = 1'b0;
    logic [31:0] ga2 = 32'd0;
    logic        rp2_v [3] = '{1'b0, 1'b0, 1'b0};
    logic [15:0] rp2_d [3] = '{16'd0, 16'd0, 16'd0};

    always @(negedge clk) begin
        g2  = m2.mem_req_o && m2.mem_gnt_i && !m2.mem_we_o;
        ga2 = m2.mem_addr_o;
        if (m2.mem_req_o && m2.mem_gnt_i) q2_addr.push_back(m2.mem_addr_o);
        if (m2.done_o) begin
            done2_cnt++;
            done2_cyc = cyc;
            done2_rd  = m2.rdata_o;
        end
    end

    always @(posedge clk) begin
        rp2_v[0] <= rst ? 1'b0 : g2;
        rp2_d[0] <= {ram_b(ga2 + 32'd1), ram_b(ga2)};
        for (int i = 1; i < 3; i++) begin
            rp2_v[i] <= rst ? 1'b0 : rp2_v[i-1];
            rp2_d[i] <= rp2_d[i-1];
        end
    end
    assign m2.mem_rdata_i = rp2_v[2] ? rp2_d[2] : 16'hEEEE;

    logic [31:0] q4_addr [$];
    logic [31:0] q4_wd   [$];
    logic [3:0]  q4_be   [$];
    logic        q4_we   [$];
    int          done4_cnt = 0, done4_cyc = 0;
    logic [31:0] done4_rd;

    always @(negedge clk) begin
        if (m4.mem_req_o && m4.mem_gnt_i) begin
            q4_addr.push_back(m4.mem_addr_o);
            q4_wd.push_back(m4.mem_wdata_o);
            q4_be.push_back(m4.mem_be_o);
            q4_we.push_back(m4.mem_we_o);
        end
        if (m4.done_o) begin
            done4_cnt++;
            done4_cyc = cyc;
            done4_rd  = m4.rdata_o;
        end
    end
    assign m4.mem_rdata_i = 32'd0;

    // One access on u1; lat = done cycle relative to accept cycle (-1 on timeout).
    task automatic acc1(input logic st, input logic [1:0] sz, input logic un,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output int base);
        int t0, d0;
        @(posedge clk); #1;
        base = q1_addr.size();
        d0   = done1_cnt;
        m1.req_i = 1'b1; m1.store_i = st; m1.size_i = sz;
        m1.unsigned_i = un; m1.addr_i = a; m1.wdata_i = wd;
        t0 = cyc;
        @(posedge clk); #1;
        m1.req_i = 1'b0;
        lat = -1;
        for (int i = 0; i < 40 && done1_cnt == d0; i++) @(posedge clk);
        if (done1_cnt != d0) lat = done1_cyc - t0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat, base, t0, d0;
        m1.req_i = 0; m1.store_i = 0; m1.size_i = 0; m1.unsigned_i = 0;
        m1.addr_i = 0; m1.wdata_i = 0; m1.mem_gnt_i = 1;
        m2.req_i = 0; m2.store_i = 0; m2.size_i = 0; m2.unsigned_i = 0;
        m2.addr_i = 0; m2.wdata_i = 0; m2.mem_gnt_i = 1;
        m4.req_i = 0; m4.store_i = 0; m4.size_i = 0; m4.unsigned_i = 0;
        m4.addr_i = 0; m4.wdata_i = 0; m4.mem_gnt_i = 1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy",  32'(m1.busy_o),    32'd0);
        check("rst_done",  32'(m1.done_o),    32'd0);
        check("rst_rdata", m1.rdata_o,        32'd0);
        check("rst_req",   32'(m1.mem_req_o), 32'd0);
        check("rst_addr",  m1.mem_addr_o,     32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // LW 0x100, bytes 11 22 33 44
        acc1(1'b0, 2'd2, 1'b0, 32'h100, 32'd0, lat, base);
        check("lw_lat",   32'(lat), 32'd6);
        check("lw_rdata", done1_rd, 32'h44332211);
        check("lw_beats", 32'(q1_addr.size() - base), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check("lw_addr", q1_addr[base+k], 32'h100 + 32'(k));
            check("lw_be",   32'(q1_be[base+k]), 32'd1);
            check("lw_we",   32'(q1_we[base+k]), 32'd0);
        end

        acc1(1'b0, 2'd0, 1'b0, 32'h200, 32'd0, lat, base);
        check("lb_lat",   32'(lat), 32'd3);
        check("lb_rdata", done1_rd, 32'hFFFFFF80);

        acc1(1'b0, 2'd0, 1'b1, 32'h200, 32'd0, lat, base);
        check("lbu_rdata", done1_rd, 32'h00000080);

        acc1(1'b0, 2'd1, 1'b0, 32'h200, 32'd0, lat, base);
        check("lh_lat",   32'(lat), 32'd4);
        check("lh_rdata", done1_rd, 32'h00007F80);

        // SW across the top of the address space
        acc1(1'b1, 2'd2, 1'b0, 32'hFFFFFFFE, 32'hA1B2C3D4, lat, base);
        check("sw_lat",   32'(lat), 32'd5);
        check("sw_rdata_kept", done1_rd, 32'h00007F80);
        check("sw_beats", 32'(q1_addr.size() - base), 32'd4);
        check("sw_addr0", q1_addr[base],   32'hFFFFFFFE);
        check("sw_addr1", q1_addr[base+1], 32'hFFFFFFFF);
        check("sw_addr2", q1_addr[base+2], 32'h00000000);
        check("sw_addr3", q1_addr[base+3], 32'h00000001);
        check("sw_data0", 32'(q1_wd[base]),   32'hD4);
        check("sw_data1", 32'(q1_wd[base+1]), 32'hC3);
        check("sw_data2", 32'(q1_wd[base+2]), 32'hB2);
        check("sw_data3", 32'(q1_wd[base+3]), 32'hA1);
        check("sw_we",    32'(q1_we[base+3]), 32'd1);

        // SH on 4-byte bus: single beat, two lanes
        @(posedge clk); #1;
        base = q4_addr.size(); d0 = done4_cnt;
        m4.req_i = 1; m4.store_i = 1; m4.size_i = 2'd1; m4.addr_i = 32'h301;
        m4.wdata_i = 32'h0000BEEF; t0 = cyc;
        @(posedge clk); #1;
        m4.req_i = 0;
        for (int i = 0; i < 40 && done4_cnt == d0; i++) @(posedge clk);
        check("sh_lat",   32'((done4_cnt != d0) ? done4_cyc - t0 : -1), 32'd2);
        check("sh_beats", 32'(q4_addr.size() - base), 32'd1);
        if (q4_addr.size() > base) begin
            check("sh_addr", q4_addr[base], 32'h301);
            check("sh_be",   32'(q4_be[base]), 32'b0011);
            check("sh_wd",   q4_wd[base], 32'h0000BEEF);
            check("sh_we",   32'(q4_we[base]), 32'd1);
        end
        check("sh_rdata_kept", done4_rd, 32'd0);

        // LW on 2-byte bus, latency 3, grant low in cycles 2 and 3
        @(posedge clk); #1;
        base = q2_addr.size(); d0 = done2_cnt;
        m2.req_i = 1; m2.store_i = 0; m2.size_i = 2'd2; m2.addr_i = 32'h401; t0 = cyc;
        for (int rel = 1; rel <= 20 && done2_cnt == d0; rel++) begin
            @(posedge clk); #1;
            m2.req_i = 0;
            m2.mem_gnt_i = (rel == 2 || rel == 3) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (rel == 2 || rel == 3) begin
                check("stall_addr", m2.mem_addr_o, 32'h403);
                check("stall_req",  32'(m2.mem_req_o), 32'd1);
                check("stall_be",   32'(m2.mem_be_o), 32'd3);
                check("stall_busy", 32'(m2.busy_o), 32'd1);
            end
        end
        m2.mem_gnt_i = 1'b1;
        check("lw2_lat",   32'((done2_cnt != d0) ? done2_cyc - t0 : -1), 32'd8);
        check("lw2_rdata", done2_rd, 32'h04030201);
        check("lw2_beats", 32'(q2_addr.size() - base), 32'd2);
        if (q2_addr.size() > base + 1) begin
            check("lw2_addr0", q2_addr[base],   32'h401);
            check("lw2_addr1", q2_addr[base+1], 32'h403);
        end

        // Reset during the second beat of a u1 LW aborts it without done
        @(posedge clk); #1;
        d0 = done1_cnt;
        m1.req_i = 1; m1.store_i = 0; m1.size_i = 2'd2; m1.addr_i = 32'h100;
        @(posedge clk); #1;
        m1.req_i = 0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy",  32'(m1.busy_o),     32'd0);
        check("abort_done",  32'(m1.done_o),     32'd0);
        check("abort_req",   32'(m1.mem_req_o),  32'd0);
        check("abort_addr",  m1.mem_addr_o,      32'd0);
        check("abort_be",    32'(m1.mem_be_o),   32'd0);
        check("abort_wd",    32'(m1.mem_wdata_o), 32'd0);
        check("abort_rdata", m1.rdata_o,         32'd0);
        repeat (8) @(posedge clk);
        check("abort_nodone", 32'(done1_cnt - d0), 32'd0);

        acc1(1'b0, 2'd0, 1'b0, 32'h200, 32'd0, lat, base);
        check("post_lb_lat",   32'(lat), 32'd3);
        check("post_lb_rdata", done1_rd, 32'hFFFFFF80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
